// File: rtl/rot3_cmd_decoder_if.sv
// rtl/rot3_cmd_decoder_if.sv - sample/command bundle for rot3_cmd_decoder (stats ports under ROT3_DEC_STATS_EN)
interface rot3_cmd_decoder_if #(
    parameter int CNT_W = 8
);
    logic [0:2]       q_in;
    logic             q_valid;
    logic             resync;
    logic             cmd_valid;
    logic             cmd_f;
    logic             cmd_r;
    logic             cmd_amb;
    logic             err;
    logic [CNT_W-1:0] net_step;
`ifdef ROT3_DEC_STATS_EN
    logic [CNT_W-1:0] fwd_cnt;
    logic [CNT_W-1:0] rev_cnt;
`endif

    modport master (
        output q_in, q_valid, resync,
        input  cmd_valid, cmd_f, cmd_r, cmd_amb, err, net_step
`ifdef ROT3_DEC_STATS_EN
        , input fwd_cnt, rev_cnt
`endif
    );

    modport slave (
        input  q_in, q_valid, resync,
        output cmd_valid, cmd_f, cmd_r, cmd_amb, err, net_step
`ifdef ROT3_DEC_STATS_EN
        , output fwd_cnt, rev_cnt
`endif
    );
endinterface

// File: rtl/rot3_cmd_decoder.sv
// rtl/rot3_cmd_decoder.sv - recovers F/R commands from successive rotate-register states
// Optional saturating F/R statistics counters enabled by ROT3_DEC_STATS_EN.
module rot3_cmd_decoder #(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rot3_cmd_decoder_if.slave     bus
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]       state;
    logic [0:2]       ref_q;
    logic             cmd_valid_q;
    logic             cmd_f_q;
    logic             cmd_r_q;
    logic             cmd_amb_q;
    logic             err_q;
    logic [CNT_W-1:0] net_q;

    logic [0:2] fwd_nxt;
    logic [0:2] rev_nxt;
    logic       uniform;
    logic       dec_hold;
    logic       dec_f;
    logic       dec_r;
    logic       dec_illegal;

    // A uniform reference maps onto itself under both rotations, so only "no change" is legal.
    always_comb begin
        fwd_nxt     = {ref_q[2], ref_q[0], ref_q[1]};
        rev_nxt     = {ref_q[1], ref_q[2], ref_q[0]};
        uniform     = (ref_q == 3'b000) || (ref_q == 3'b111);
        dec_hold    = (bus.q_in == ref_q);
        dec_f       = !uniform && (bus.q_in == fwd_nxt);
        dec_r       = !uniform && (bus.q_in == rev_nxt);
        dec_illegal = !(dec_hold || dec_f || dec_r);
    end

`ifdef ROT3_DEC_STATS_EN
    logic [CNT_W-1:0] fwd_q;
    logic [CNT_W-1:0] rev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= '0;
            rev_q <= '0;
        end else if (bus.resync) begin
            fwd_q <= '0;
            rev_q <= '0;
        end else if (bus.q_valid && state == ST_TRACK && !dec_illegal) begin
            if (dec_f && fwd_q != {CNT_W{1'b1}}) begin
                fwd_q <= fwd_q + CNT_W'(1);
            end
            if (dec_r && rev_q != {CNT_W{1'b1}}) begin
                rev_q <= rev_q + CNT_W'(1);
            end
        end
    end

    assign bus.fwd_cnt = fwd_q;
    assign bus.rev_cnt = rev_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            ref_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_f_q     <= 1'b0;
            cmd_r_q     <= 1'b0;
            cmd_amb_q   <= 1'b0;
            err_q       <= 1'b0;
            net_q       <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            cmd_f_q     <= 1'b0;
            cmd_r_q     <= 1'b0;
            cmd_amb_q   <= 1'b0;
            if (bus.resync) begin
                err_q <= 1'b0;
                net_q <= '0;
                if (bus.q_valid) begin
                    ref_q <= bus.q_in;
                    state <= ST_TRACK;
                end else begin
                    state <= ST_EMPTY;
                end
            end else if (bus.q_valid) begin
                case (state)
                    ST_EMPTY: begin
                        ref_q <= bus.q_in;
                        state <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        ref_q <= bus.q_in;
                        if (dec_illegal) begin
                            err_q <= 1'b1;
                            state <= ST_FAULT;
                        end else begin
                            cmd_valid_q <= 1'b1;
                            cmd_f_q     <= dec_f;
                            cmd_r_q     <= dec_r;
                            cmd_amb_q   <= uniform;
                            if (dec_f) begin
                                net_q <= net_q + CNT_W'(1);
                            end else if (dec_r) begin
                                net_q <= net_q - CNT_W'(1);
                            end
                        end
                    end
                    ST_FAULT: begin
                        state <= ST_FAULT;
                    end
                    default: begin
                        state <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_f     = cmd_f_q;
    assign bus.cmd_r     = cmd_r_q;
    assign bus.cmd_amb   = cmd_amb_q;
    assign bus.err       = err_q;
    assign bus.net_step  = net_q;
endmodule

// File: tb/tb_rot3_cmd_decoder.sv
// tb/tb_rot3_cmd_decoder.sv - self-checking bench for rot3_cmd_decoder (CNT_W=4, ROT3_DEC_STATS_EN aware)
module tb_rot3_cmd_decoder;
    localparam int W = 4;

    logic clk;
    logic rst_n;

    rot3_cmd_decoder_if #(.CNT_W(W)) bus ();

    rot3_cmd_decoder #(.CNT_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:2] q;
        logic       qv;
        logic       rs;
        logic       cv;
        logic       f;
        logic       r;
        logic       amb;
        logic       err;
        int         net;
    } vec_t;

    typedef struct {
        int   id;
        logic cv;
        logic f;
        logic r;
        logic amb;
        logic err;
        int   net;
        bit   chk_st;
        int   fwd;
        int   rev;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    function automatic void cmp(string nm, int id, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s[%0d]: got %0d expected %0d", nm, id, act, exp);
    endfunction

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            cmp("scoreboard_empty", -1, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        cmp("cmd_valid", e.id, int'(bus.cmd_valid), int'(e.cv));
        cmp("cmd_f",     e.id, int'(bus.cmd_f),     int'(e.f));
        cmp("cmd_r",     e.id, int'(bus.cmd_r),     int'(e.r));
        cmp("cmd_amb",   e.id, int'(bus.cmd_amb),   int'(e.amb));
        cmp("err",       e.id, int'(bus.err),       int'(e.err));
        cmp("net_step",  e.id, int'($signed(bus.net_step)), e.net);
`ifdef ROT3_DEC_STATS_EN
        if (e.chk_st) begin
            cmp("fwd_cnt", e.id, int'(bus.fwd_cnt), e.fwd);
            cmp("rev_cnt", e.id, int'(bus.rev_cnt), e.rev);
        end
`endif
    endtask

    // Called at a negedge: drive, register expectation, then sample at the following negedge.
    task automatic drive(input logic [0:2] q, input logic qv, input logic rs, input exp_t e);
        bus.q_in    = q;
        bus.q_valid = qv;
        bus.resync  = rs;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    function automatic exp_t mk(int id, logic cv, logic f, logic r, logic amb, logic err, int net,
                                bit chk_st, int fwd, int rev);
        exp_t e;
        e.id = id; e.cv = cv; e.f = f; e.r = r; e.amb = amb; e.err = err; e.net = net;
        e.chk_st = chk_st; e.fwd = fwd; e.rev = rev;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt[$];
        logic [2:0] cur;
        int         net;
        int         fwd;
        int         rev;

        //               q       qv    rs    cv    f     r     amb   err   net
        vt.push_back('{3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0});
        vt.push_back('{3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1});
        vt.push_back('{3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0});
        vt.push_back('{3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1});
        vt.push_back('{3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1});
        vt.push_back('{3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1});
        vt.push_back('{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0});
        vt.push_back('{3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  0});
        vt.push_back('{3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  0});
        vt.push_back('{3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  0});
        vt.push_back('{3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  0});
        vt.push_back('{3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0});
        vt.push_back('{3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1});
        vt.push_back('{3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0});
        vt.push_back('{3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0});
        vt.push_back('{3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  0});
        vt.push_back('{3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  0});
        vt.push_back('{3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0});
        vt.push_back('{3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0});
        vt.push_back('{3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1});
        vt.push_back('{3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,  0});
        vt.push_back('{3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  0});

        rst_n       = 1'b0;
        bus.q_in    = 3'b000;
        bus.q_valid = 1'b0;
        bus.resync  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmp("rst_cmd_valid", 0, int'(bus.cmd_valid), 0);
        cmp("rst_err",       0, int'(bus.err),       0);
        cmp("rst_net_step",  0, int'(bus.net_step),  0);
        cmp("rst_cmd_f",     0, int'(bus.cmd_f | bus.cmd_r | bus.cmd_amb), 0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].q, vt[i].qv, vt[i].rs,
                  mk(i, vt[i].cv, vt[i].f, vt[i].r, vt[i].amb, vt[i].err, vt[i].net, 1'b0, 0, 0));
        end

        // Long forward run: net_step wraps at 4 bits, fwd_cnt saturates at 15.
        cur = 3'b100;
        drive(cur, 1'b1, 1'b1, mk(100, 0, 0, 0, 0, 0, 0, 1'b1, 0, 0));
        fwd = 0;
        for (int i = 1; i <= 20; i++) begin
            cur = {cur[0], cur[2:1]};
            fwd = (fwd < 15) ? fwd + 1 : 15;
            net = int'($signed(W'(i)));
            drive(cur, 1'b1, 1'b0, mk(100 + i, 1, 1, 0, 0, 0, net, 1'b1, fwd, 0));
        end
        rev = 0;
        net = 4;
        for (int i = 1; i <= 3; i++) begin
            cur = {cur[1:0], cur[2]};
            rev++;
            net--;
            drive(cur, 1'b1, 1'b0, mk(200 + i, 1, 0, 1, 0, 0, net, 1'b1, 15, rev));
        end

        // Asynchronous reset while cmd_valid is high.
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_rst_cmd_valid", 300, int'(bus.cmd_valid), 0);
        cmp("async_rst_cmd_r",     300, int'(bus.cmd_r),     0);
        cmp("async_rst_net_step",  300, int'(bus.net_step),  0);
`ifdef ROT3_DEC_STATS_EN
        cmp("async_rst_fwd_cnt",   300, int'(bus.fwd_cnt),   0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b010, 1'b1, 1'b0, mk(301, 0, 0, 0, 0, 0, 0, 1'b1, 0, 0));
        drive(3'b001, 1'b1, 1'b0, mk(302, 1, 1, 0, 0, 0, 1, 1'b1, 1, 0));
        bus.q_valid = 1'b0;

        cmp("scoreboard_drained", 400, exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
